// File: rtl/button_debounce.sv
// Push-button front end: two-flop synchroniser, bounce filter and
// one-cycle press / release / long-press pulses, plus a clean level.
module button_debounce #(
    parameter int unsigned DB_CYCLES      = 1000000,
    parameter int unsigned LONG_CYCLES    = 50000000,
    parameter bit          BTN_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = (LONG_CYCLES == 0) ? 1 : $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((LONG_CYCLES == 0) ? 0 : LONG_CYCLES - 1);
    localparam bit                LONG_EN   = (LONG_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        DOWN         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        sync_q;
    logic              btn_s;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    // Two-flop synchroniser; polarity fix is applied after the second
    // flop so both flops still reset to 0 regardless of BTN_ACTIVE_LOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], btn_in};
    end

    assign btn_s = sync_q[1] ^ BTN_ACTIVE_LOW;

    // Debounce FSM with registered level and pulse outputs. A level change
    // is accepted only after DB_CYCLES consecutive agreeing samples; the
    // first disagreeing sample drops back to the settled state silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= DB_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= DOWN;
                        btn_press <= 1'b1;
                        btn_level <= 1'b1;
                        db_cnt    <= '0;
                        hold_cnt  <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                DOWN: begin
                    // hold_cnt saturates at LONG_CYCLES, so btn_long fires once per press
                    if (LONG_EN && (hold_cnt < HOLD_MAX)) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        if (hold_cnt == HOLD_LAST) btn_long <= 1'b1;
                    end
                    if (!btn_s) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= DB_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    // hold_cnt is frozen here: release glitches do not advance long-press
                    if (btn_s) begin
                        state  <= DOWN;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= IDLE;
                        btn_release <= 1'b1;
                        btn_level   <= 1'b0;
                        db_cnt      <= '0;
                        hold_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DB_CYCLES=4, LONG_CYCLES=16.
// Each step drives inputs at the falling edge and samples 1ns after the
// following rising edge; expected outputs are packed {level,press,release,long}.
module tb_button_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level, btn_press, btn_release, btn_long;

    int checks = 0;
    int errors = 0;

    button_debounce #(
        .DB_CYCLES     (4),
        .LONG_CYCLES   (16),
        .BTN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       btn;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic b, input logic [3:0] e);
        vec_t v;
        v.rst = r; v.btn = b; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic b);
        @(negedge clk);
        rst_n  = r;
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got {lvl,prs,rel,lng}=%b want %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {btn_level, btn_press, btn_release, btn_long};
    endfunction

    // Pulse invariants: press/release exclusive, no pulse two cycles running.
    logic p_prs = 1'b0, p_rel = 1'b0, p_lng = 1'b0;
    always @(posedge clk) begin
        #1;
        if (btn_press || btn_release || btn_long) begin
            checks++;
            if ((btn_press && btn_release) || (btn_press && p_prs) ||
                (btn_release && p_rel) || (btn_long && p_lng)) begin
                errors++;
                $display("FAIL pulse_rule got prs=%b rel=%b lng=%b prev=%b%b%b want isolated pulses",
                         btn_press, btn_release, btn_long, p_prs, p_rel, p_lng);
            end
        end
        p_prs = btn_press;
        p_rel = btn_release;
        p_lng = btn_long;
    end

    initial begin
        int n_long, long_at, n_prs, n_rel;

        // reset held while pin toggles, then quiet release
        add(0, 1, 4'b0000); add(0, 0, 4'b0000); add(0, 1, 4'b0000); add(0, 0, 4'b0000);
        repeat (3) add(1, 0, 4'b0000);
        // clean press: capture edge k, press after edge k+5
        repeat (5) add(1, 1, 4'b0000);
        add(1, 1, 4'b1100);
        repeat (4) add(1, 1, 4'b1000);
        // clean release (10-cycle press, no long)
        repeat (5) add(1, 0, 4'b1000);
        add(1, 0, 4'b0010);
        repeat (2) add(1, 0, 4'b0000);
        // bounce press 1,1,1,0,1,1,0 then steady 1
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 0, 4'b0000);
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 0, 4'b0000);
        repeat (5) add(1, 1, 4'b0000);
        add(1, 1, 4'b1100);
        add(1, 1, 4'b1000);
        // release bounce 0,0,1 then steady 0
        add(1, 0, 4'b1000); add(1, 0, 4'b1000); add(1, 1, 4'b1000);
        repeat (5) add(1, 0, 4'b1000);
        add(1, 0, 4'b0010);
        repeat (2) add(1, 0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].btn);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // long press: 40 cycles held after DOWN entry
        step(1, 1);
        for (int i = 1; i <= 5; i++) begin
            step(1, 1);
            if (i == 4) chk("long_prepress", outs(), 4'b0000);
            if (i == 5) chk("long_press", outs(), 4'b1100);
        end
        n_long = 0; long_at = 0; n_prs = 0;
        for (int j = 1; j <= 40; j++) begin
            step(1, 1);
            if (btn_long) begin n_long++; long_at = j; end
            if (btn_press) n_prs++;
        end
        chk_int("long_count", n_long, 1);
        chk_int("long_edge", long_at, 16);
        chk_int("long_no_repress", n_prs, 0);

        // async reset while DOWN: outputs clear without a clock edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset", outs(), 4'b0000);
        step(0, 1);
        chk("reset_hold", outs(), 4'b0000);

        // button still held at reset release: debounced as a fresh press
        step(1, 1);
        chk("held_cap", outs(), 4'b0000);
        for (int i = 1; i <= 5; i++) begin
            step(1, 1);
            if (i == 4) chk("held_pre", outs(), 4'b0000);
            if (i == 5) chk("held_press", outs(), 4'b1100);
        end
        step(1, 0);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0);
            if (i == 4) chk("held_prerel", outs(), 4'b1000);
            if (i == 5) chk("held_release", outs(), 4'b0010);
        end
        repeat (2) step(1, 0);

        // reset two cycles before the press would land
        step(1, 1);
        step(1, 1);
        step(1, 1);
        step(1, 1);
        chk("mid_pre", outs(), 4'b0000);
        step(0, 1);
        chk("mid_rst0", outs(), 4'b0000);
        step(0, 0);
        chk("mid_rst1", outs(), 4'b0000);
        n_prs = 0; n_rel = 0;
        for (int j = 0; j < 20; j++) begin
            step(1, 0);
            if (btn_press) n_prs++;
            if (btn_release) n_rel++;
        end
        chk_int("mid_no_press", n_prs, 0);
        chk_int("mid_no_release", n_rel, 0);
        chk("mid_final", outs(), 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
